// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter: FSM state, grant encoding and default bus widths.
// Other blocks on the control path use the same width defaults.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF  = 6;
  localparam int DATA_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 15;
  localparam int TO_W_DEF    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arbiter_rr.sv
// Two-requester round-robin pick; purely combinational, zero latency, no backpressure of its own.
// The last-grant history lives in the parent so the pick only advances when a grant is taken.
module rr_arbiter2
  import mem_arbiter_pkg::*;
(
  input  logic i_if_req,
  input  logic i_d_req,
  input  gnt_t i_last_grant,
  output logic o_vld,
  output gnt_t o_gnt
);

  always_comb begin
    o_vld = i_if_req | i_d_req;
    o_gnt = GNT_IF;
    if (i_if_req && i_d_req) begin
      // on a tie the side that did not win last time goes first
      o_gnt = (i_last_grant == GNT_IF) ? GNT_D : GNT_IF;
    end else if (i_d_req) begin
      o_gnt = GNT_D;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-port memory between fetch and load/store, one timeout-guarded transaction at a time.
// Best case ack lands in the third cycle after the request is seen; requesters hold req until their ack.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TO_W    = TO_W_DEF
) (
  input  logic              clk_main,
  input  logic              reset,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,

  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,

  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  arb_state_t        r_state, w_state_nxt;
  gnt_t              r_gnt, w_gnt_nxt;
  gnt_t              r_last, w_last_nxt;
  logic [TO_W-1:0]   r_cnt, w_cnt_nxt;

  logic              r_mem_req, w_mem_req_nxt;
  logic              r_mem_we, w_mem_we_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

  logic              r_if_ack, w_if_ack_nxt;
  logic              r_if_err, w_if_err_nxt;
  logic [DATA_W-1:0] r_if_rdata, w_if_rdata_nxt;
  logic              r_d_ack, w_d_ack_nxt;
  logic              r_d_err, w_d_err_nxt;
  logic [DATA_W-1:0] r_d_rdata, w_d_rdata_nxt;

  logic              w_pick_vld;
  gnt_t              w_pick;
  logic              w_timeout;
  logic              w_done;
  logic [DATA_W-1:0] w_resp_dat;

  rr_arbiter2 u_rr (
    .i_if_req     (if_req),
    .i_d_req      (d_req),
    .i_last_grant (r_last),
    .o_vld        (w_pick_vld),
    .o_gnt        (w_pick)
  );

  assign w_timeout  = (r_cnt == TO_W'(TIMEOUT - 1));
  assign w_done     = mem_ack | w_timeout;
  // writes and aborted transactions both return zero data
  assign w_resp_dat = (mem_ack && !r_mem_we) ? mem_rdata : '0;

  always_comb begin
    w_state_nxt     = r_state;
    w_gnt_nxt       = r_gnt;
    w_last_nxt      = r_last;
    w_cnt_nxt       = r_cnt;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_if_ack_nxt    = 1'b0;
    w_if_err_nxt    = 1'b0;
    w_if_rdata_nxt  = '0;
    w_d_ack_nxt     = 1'b0;
    w_d_err_nxt     = 1'b0;
    w_d_rdata_nxt   = '0;

    case (r_state)
      IDLE: begin
        if (w_pick_vld) begin
          w_gnt_nxt     = w_pick;
          w_last_nxt    = w_pick;
          w_cnt_nxt     = '0;
          w_mem_req_nxt = 1'b1;
          if (w_pick == GNT_IF) begin
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = if_addr;
            w_mem_wdata_nxt = '0;
          end else begin
            w_mem_we_nxt    = d_we;
            w_mem_addr_nxt  = d_addr;
            w_mem_wdata_nxt = d_wdata;
          end
          w_state_nxt = BUSY;
        end
      end

      BUSY: begin
        if (w_done) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = RESP;
          // response registers load here so the ack is visible throughout RESP
          if (r_gnt == GNT_IF) begin
            w_if_ack_nxt   = 1'b1;
            w_if_err_nxt   = ~mem_ack;
            w_if_rdata_nxt = w_resp_dat;
          end else begin
            w_d_ack_nxt   = 1'b1;
            w_d_err_nxt   = ~mem_ack;
            w_d_rdata_nxt = w_resp_dat;
          end
        end else begin
          w_cnt_nxt = r_cnt + TO_W'(1);
        end
      end

      RESP: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt   = IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_main or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_gnt       <= GNT_IF;
      r_last      <= GNT_D;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_if_err    <= 1'b0;
      r_if_rdata  <= '0;
      r_d_ack     <= 1'b0;
      r_d_err     <= 1'b0;
      r_d_rdata   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_last      <= w_last_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_if_ack    <= w_if_ack_nxt;
      r_if_err    <= w_if_err_nxt;
      r_if_rdata  <= w_if_rdata_nxt;
      r_d_ack     <= w_d_ack_nxt;
      r_d_err     <= w_d_err_nxt;
      r_d_rdata   <= w_d_rdata_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_ack    = r_if_ack;
  assign if_err    = r_if_err;
  assign if_rdata  = r_if_rdata;
  assign d_ack     = r_d_ack;
  assign d_err     = r_d_err;
  assign d_rdata   = r_d_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: bench-side memory, two requesters and a transaction-level model.
// Directed scenarios first, then a random contention phase.
module tb_mem_arbiter;

  localparam int TO = 15;

  logic        clk_main;
  logic        reset;
  logic        if_req, d_req, d_we;
  logic [5:0]  if_addr, d_addr, mem_addr;
  logic [15:0] d_wdata, if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic        if_ack, if_err, d_ack, d_err;
  logic        mem_req, mem_we, mem_ack;

  mem_arbiter dut (
    .clk_main (clk_main), .reset (reset),
    .if_req (if_req), .if_addr (if_addr), .if_ack (if_ack), .if_rdata (if_rdata), .if_err (if_err),
    .d_req (d_req), .d_we (d_we), .d_addr (d_addr), .d_wdata (d_wdata),
    .d_ack (d_ack), .d_rdata (d_rdata), .d_err (d_err),
    .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata), .mem_ack (mem_ack)
  );

  initial clk_main = 1'b0;
  always #5 clk_main = ~clk_main;

  int n_chk, n_fail;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [15:0] mem_m [64];
  int  cyc;
  int  ifs, ds;                 // requester state: 0 idle, 1 waiting for grant, 2 granted
  int  p_if, p_d, p_back, p_drop, f_d;
  bit  m_busy, last, exp_who;
  int  free_from, exp_start, exp_ack, exp_len, cur_d, gnt_cyc;
  logic [5:0]  exp_addr;
  logic        exp_we, exp_err;
  logic [15:0] exp_wdata, exp_rdata;
  bit  r_act;
  int  r_k, last_len;
  int  n_if_ack, n_d_ack, last_ack_cyc;
  logic [15:0] last_if_rdata, last_d_rdata;
  logic        last_if_err, last_d_err;
  bit  gnt_q [$];

  task automatic observe();
    @(negedge clk_main);
    cyc++;
    chk_eq("ack_exclusive", 32'(if_ack & d_ack), 0);
    if (if_ack) begin n_if_ack++; last_if_rdata = if_rdata; last_if_err = if_err; last_ack_cyc = cyc; end
    if (d_ack)  begin n_d_ack++;  last_d_rdata  = d_rdata;  last_d_err  = d_err;  last_ack_cyc = cyc; end

    // bench memory: answers in BUSY cycle cur_d, otherwise throws stray acks at an idle arbiter
    if (mem_req) begin
      if (!r_act) begin
        r_act = 1; r_k = 0;
        chk_eq("mem_req_start_cyc", cyc, exp_start);
      end else begin
        r_k++;
      end
      chk_eq("mem_addr", 32'(mem_addr), 32'(exp_addr));
      chk_eq("mem_we", 32'(mem_we), 32'(exp_we));
      chk_eq("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      mem_ack   = (r_k == cur_d);
      mem_rdata = (mem_ack && !mem_we) ? mem_m[mem_addr] : 16'($urandom);
      if (mem_ack && mem_we) mem_m[mem_addr] = mem_wdata;
    end else begin
      r_act     = 0;
      mem_ack   = ($urandom_range(3) == 0);
      mem_rdata = 16'($urandom);
    end

    if (m_busy && cyc == exp_ack) begin
      chk_eq("if_ack", 32'(if_ack), 32'(exp_who == 1'b0));
      chk_eq("d_ack", 32'(d_ack), 32'(exp_who == 1'b1));
      chk_eq("rdata", 32'(exp_who ? d_rdata : if_rdata), 32'(exp_rdata));
      chk_eq("err", 32'(exp_who ? d_err : if_err), 32'(exp_err));
      chk_eq("other_rdata", 32'(exp_who ? if_rdata : d_rdata), 0);
      chk_eq("other_err", 32'(exp_who ? if_err : d_err), 0);
      chk_eq("mem_req_dropped", 32'(mem_req), 0);
      chk_eq("busy_len", r_k + 1, exp_len);
      last_len  = r_k + 1;
      m_busy    = 0;
      free_from = cyc + 1;
      if (!exp_who) begin
        if ($urandom_range(99) < p_back) begin ifs = 1; if_req = 1; if_addr = 6'($urandom); end
        else begin ifs = 0; if_req = 0; end
      end else begin
        if ($urandom_range(99) < p_back) begin
          ds = 1; d_req = 1; d_we = 1'($urandom); d_addr = 6'($urandom); d_wdata = 16'($urandom);
        end else begin ds = 0; d_req = 0; end
      end
    end else begin
      chk_eq("no_unexpected_ack", 32'({if_ack, d_ack}), 0);
    end
  endtask

  task automatic decide();
    if (ifs == 0 && $urandom_range(99) < p_if) begin ifs = 1; if_req = 1; if_addr = 6'($urandom); end
    if (ifs == 2 && if_req && $urandom_range(99) < p_drop) begin if_req = 0; if_addr = 6'($urandom); end
    if (ds == 0 && $urandom_range(99) < p_d) begin
      ds = 1; d_req = 1; d_we = 1'($urandom); d_addr = 6'($urandom); d_wdata = 16'($urandom);
    end
    if (ds == 2 && d_req && $urandom_range(99) < p_drop) begin
      d_req = 0; d_we = 1'($urandom); d_addr = 6'($urandom); d_wdata = 16'($urandom);
    end

    if (!m_busy && cyc >= free_from && (if_req || d_req)) begin
      exp_who = (if_req && d_req) ? ~last : d_req;
      last    = exp_who;
      gnt_q.push_back(exp_who);
      gnt_cyc = cyc;
      if (!exp_who) begin
        exp_addr = if_addr; exp_we = 0; exp_wdata = 0; ifs = 2;
      end else begin
        exp_addr = d_addr; exp_we = d_we; exp_wdata = d_wdata; ds = 2;
      end
      if (f_d >= 0) cur_d = f_d;
      else cur_d = ($urandom_range(3) == 0) ? int'($urandom_range(20, 13)) : int'($urandom_range(5));
      if (cur_d < TO) begin
        exp_len = cur_d + 1; exp_err = 0; exp_rdata = exp_we ? 16'h0 : mem_m[exp_addr];
      end else begin
        exp_len = TO; exp_err = 1; exp_rdata = 16'h0;
      end
      exp_start = cyc + 1;
      exp_ack   = cyc + 1 + exp_len;
      m_busy    = 1;
    end
  endtask

  task automatic step();
    observe();
    decide();
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while ((m_busy || ifs != 0 || ds != 0) && n < max_cyc) begin
      step();
      n++;
    end
    chk_eq("drain_in_time", 32'(m_busy || ifs != 0 || ds != 0), 0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    chk_eq("rst_mem_req", 32'(mem_req), 0);
    chk_eq("rst_acks", 32'({if_ack, d_ack}), 0);
    chk_eq("rst_errs", 32'({if_err, d_err}), 0);
    chk_eq("rst_rdata", 32'({if_rdata, d_rdata}), 0);
    chk_eq("rst_mem_bus", 32'({mem_we, mem_addr, mem_wdata}), 0);
    mem_ack = 0;
    @(negedge clk_main);
    reset = 1'b1;
    m_busy = 0; r_act = 0; free_from = 0; last = 1;
    ifs = if_req ? 1 : 0;
    ds  = d_req  ? 1 : 0;
  endtask

  int base;
  logic [15:0] want;

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    mem_ack = 0; mem_rdata = 0;
    for (int i = 0; i < 64; i++) mem_m[i] = 16'($urandom);
    mem_m[5] = 16'hA5C3;
    ifs = 0; ds = 0; m_busy = 0; r_act = 0; r_k = 0; last = 1; free_from = 0;
    exp_start = -1; exp_ack = -1; f_d = -1;
    p_if = 0; p_d = 0; p_back = 0; p_drop = 0;
    n_if_ack = 0; n_d_ack = 0;

    reset = 1'b1;
    #2 reset = 1'b0;
    @(negedge clk_main);
    chk_eq("reset_mem_req", 32'(mem_req), 0);
    chk_eq("reset_acks", 32'({if_ack, d_ack, if_err, d_err}), 0);
    chk_eq("reset_rdata", 32'({if_rdata, d_rdata}), 0);
    chk_eq("reset_mem_bus", 32'({mem_we, mem_addr, mem_wdata}), 0);
    @(negedge clk_main);
    reset = 1'b1;

    // fetch only, immediate memory ack
    observe();
    if_req = 1; if_addr = 6'h05; ifs = 1; f_d = 0;
    decide();
    base = n_if_ack;
    drain(40);
    chk_eq("fetch_rdata", 32'(last_if_rdata), 32'h0000A5C3);
    chk_eq("fetch_err", 32'(last_if_err), 0);
    chk_eq("fetch_ack_latency", last_ack_cyc - gnt_cyc, 2);
    chk_eq("fetch_ack_count", n_if_ack - base, 1);
    chk_eq("fetch_busy_len", last_len, 1);

    // data write, memory answers after 4 waiting cycles
    observe();
    d_req = 1; d_we = 1; d_addr = 6'h3F; d_wdata = 16'h1234; ds = 1; f_d = 4;
    decide();
    drain(40);
    chk_eq("write_mem", 32'(mem_m[63]), 32'h00001234);
    chk_eq("write_rdata", 32'(last_d_rdata), 0);
    chk_eq("write_err", 32'(last_d_err), 0);
    chk_eq("write_busy_len", last_len, 5);

    // data read that never gets a memory ack, then a late stray ack
    observe();
    d_req = 1; d_we = 0; d_addr = 6'h07; d_wdata = 16'hBEEF; ds = 1; f_d = 99;
    decide();
    drain(40);
    chk_eq("timeout_err", 32'(last_d_err), 1);
    chk_eq("timeout_rdata", 32'(last_d_rdata), 0);
    chk_eq("timeout_busy_len", last_len, TO);
    base = n_d_ack + n_if_ack;
    step();
    observe(); mem_ack = 1; mem_rdata = 16'hFFFF; decide();
    repeat (4) step();
    chk_eq("late_ack_ignored", (n_d_ack + n_if_ack) - base, 0);

    // continuous contention right after reset
    do_reset();
    if_req = 1; if_addr = 6'($urandom); ifs = 1;
    d_req = 1; d_we = 1'($urandom); d_addr = 6'($urandom); d_wdata = 16'($urandom); ds = 1;
    p_back = 100; f_d = -1;
    gnt_q.delete();
    decide();
    for (int n = 0; n < 300 && gnt_q.size() < 4; n++) step();
    chk_eq("contention_grants", gnt_q.size() >= 4, 1);
    if (gnt_q.size() >= 4) begin
      chk_eq("contention_g0", 32'(gnt_q[0]), 0);
      chk_eq("contention_g1", 32'(gnt_q[1]), 1);
      chk_eq("contention_g2", 32'(gnt_q[2]), 0);
      chk_eq("contention_g3", 32'(gnt_q[3]), 1);
    end
    p_back = 0;
    drain(200);

    // reset in the middle of a fetch; afterwards a tie goes to fetch
    observe();
    if_req = 1; if_addr = 6'h09; ifs = 1; f_d = 10;
    decide();
    step();
    step();
    chk_eq("pre_reset_busy", 32'(mem_req), 1);
    base = n_if_ack;
    d_req = 1; d_we = 0; d_addr = 6'h2A; d_wdata = 16'h0;
    do_reset();
    chk_eq("reset_no_ack", n_if_ack - base, 0);
    gnt_q.delete();
    f_d = 1;
    decide();
    drain(100);
    chk_eq("post_reset_grants", gnt_q.size(), 2);
    if (gnt_q.size() >= 2) begin
      chk_eq("post_reset_tie_fetch", 32'(gnt_q[0]), 0);
      chk_eq("post_reset_then_data", 32'(gnt_q[1]), 1);
    end

    // fetch request dropped during BUSY still completes
    observe();
    if_req = 1; if_addr = 6'h11; ifs = 1; f_d = 3;
    want = mem_m[6'h11];
    decide();
    base = n_if_ack;
    observe();
    if_req = 0; if_addr = 6'h22;
    decide();
    drain(40);
    chk_eq("early_drop_ack_count", n_if_ack - base, 1);
    chk_eq("early_drop_rdata", 32'(last_if_rdata), 32'(want));

    // random traffic
    f_d = -1; p_if = 35; p_d = 35; p_back = 50; p_drop = 10;
    repeat (3000) step();
    p_if = 0; p_d = 0; p_back = 0; p_drop = 0;
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test, required completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port 64x16 memory between two requesters: the instruction-fetch side of the control path (read-only, PC address) and the datapath load/store side (MM/MW).
- Sits between control_path/datapath and the memory.
- Arbitrates round-robin, runs one memory transaction at a time with a req/ack handshake, and guards every transaction with a timeout.

Parameters:
- ADDR_W, 6, address width (matches the 6-bit PC).
- DATA_W, 16, data width (matches the instruction word).
- TIMEOUT, 15, max BUSY cycles without mem_ack before abort; 1..2^TO_W-1.
- TO_W, 4, timeout counter width.

Ports:
- clk_main  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetched word; valid only while if_ack=1.
- if_err  out  1  fetch timed out; valid with if_ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1=write, 0=read; stable while d_req is high.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle data completion pulse.
- d_rdata  out  DATA_W  read data; valid only while d_ack=1; 0 for writes.
- d_err  out  1  data timed out; valid with d_ack.
- mem_req  out  1  memory request; held until mem_ack or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid while mem_ack=1.
- mem_ack  in  1  memory completion; sampled only in BUSY.

Behaviour:
- All outputs are registered.
- Reset (reset=0, async) clears:
  - state to IDLE;
  - all ack, err and mem_* outputs to 0, and rdata outputs to 0;
  - timeout counter to 0;
  - last_grant to DATA, so the first tie goes to fetch.
- IDLE:
  - no request: stay in IDLE.
  - only one requester high: grant it.
  - both high: grant the requester that is not last_grant.
  - on grant: latch the grant and that requester's addr/we/wdata (fetch forces we=0), update last_grant, go to BUSY.
  - mem_req=1 in the cycle after the request was sampled.
- BUSY:
  - mem_req=1, with mem_addr/mem_we/mem_wdata held from the latch.
  - mem_ack=1: capture mem_rdata (forced to 0 for writes), clear err, go to RESP; mem_req drops next cycle.
  - mem_ack=0: increment the counter.
  - counter reaches TIMEOUT with no ack: mem_req drops, set err, rdata=0, go to RESP.
  - The counter clears on every entry to BUSY.
- RESP:
  - Asserts the granted requester's ack for exactly one cycle, with its rdata/err; the other requester's outputs stay 0.
  - Next state is always IDLE.
  - Minimum transaction time is 3 cycles from request sample to ack (IDLE, BUSY with immediate ack, RESP).
- Requester rule:
  - Requesters drop req in the cycle after ack.
  - A req still high in IDLE after RESP is treated as a new request.
  - A req dropped mid-transaction does not cancel it: the memory access completes and the ack is still issued.
- Inputs are sampled only at grant; changes after grant are ignored.
- mem_ack outside BUSY (late ack after a timeout) is ignored and does not disturb state.
- A reset asserted mid-transaction aborts immediately with no ack; mem_req=0 asynchronously.
- Fairness: under continuous contention, grants alternate fetch, data, fetch, ...; neither requester waits more than one foreign transaction.

Decomposition:
- Shared package:
  - state encoding IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - grant encoding GNT_IF=1'b0, GNT_D=1'b1;
  - ADDR_W/DATA_W defaults, shared with control_path.
- One natural sub-module, rr_arbiter2: a two-requester round-robin pick from (if_req, d_req, last_grant). It is combinational, with last_grant held in the parent.
- FSM, latch and timeout counter stay in the parent.

Test Plan:
- Fetch only: if_req=1, if_addr=6'h05, mem_ack in the first BUSY cycle with mem_rdata=16'hA5C3 -> mem_req high one cycle with mem_addr=05 and mem_we=0; if_ack one cycle with if_rdata=A5C3 and if_err=0, 3 cycles after the request was sampled.
- Data write: d_req=1, d_we=1, d_addr=6'h3F, d_wdata=16'h1234, mem_ack after 4 BUSY cycles -> mem_wdata=1234 and mem_we=1 throughout BUSY; d_ack with d_rdata=0 and d_err=0.
- Contention: both req high continuously for 4 transactions after reset -> grant order fetch, data, fetch, data; if_ack and d_ack never in the same cycle.
- Timeout: d_req read, mem_ack held 0 -> mem_req drops after 15 BUSY cycles; d_ack=1, d_err=1, d_rdata=0. A mem_ack pulse 2 cycles later is ignored.
- Reset mid-BUSY: reset=0 during a fetch -> mem_req, if_ack and state go to 0/IDLE immediately. After release, a tie with both req high grants fetch first.
- Early drop: if_req dropped one cycle into BUSY -> memory read still completes and if_ack is still pulsed once.
